// File: rtl/cu_dispatch.sv
// cu_dispatch: issue stage between the program sequencer and cu_top.
//
// Takes 24-bit compute instructions over a valid/ready handshake and decodes
// them into cu_top unit controls in the accept cycle (EX). The destination and
// unit are registered for one cycle (WB), when the register-file write is
// steered to the producing unit and that unit's flags are captured into ASTAT
// and STKY. Bus-connect register writes use the write port only in cycles with
// no compute write-back.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   instr_valid/instr/ready    instruction handshake
//                              instr = {unit[1:0], op[7:0], rn, rx, ry, rsvd[1:0]}
//   bc_wr_req/addr/ack         bus-connect register-file write request
//   ps_alu_* / ps_mul_* /
//   ps_shf_*                   unit enables and decoded op fields (EX)
//   ps_xb_raddx/raddy          register-file read addresses (EX)
//   ps_xb_wadd                 register-file write address (WB or bus-connect)
//   ps_xb_w_cuEn               one-hot write-back source {SHF, MUL, ALU}
//   ps_xb_w_bcEn               bus-connect write enable
//   alu_ps_*, mul_ps_*,
//   shf_ps_*                   flags from cu_top, sampled in the WB cycle
//   stky_clr                   clear all sticky bits
//   astat                      {sz, sv, mn, mv, av, ac, an, az}
//   stky                       {sv_s, mv_s, av_s}
`timescale 1ns/1ps
module cu_dispatch #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int SIGNAL_WIDTH  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    input  logic [23:0]              instr,
    output logic                     instr_ready,
    input  logic                     bc_wr_req,
    input  logic [ADDRESS_WIDTH-1:0] bc_wr_addr,
    output logic                     bc_wr_ack,
    output logic                     ps_alu_en,
    output logic                     ps_alu_log,
    output logic [1:0]               ps_alu_hc,
    output logic [2:0]               ps_alu_sc,
    output logic                     ps_alu_sat,
    output logic                     ps_mul_en,
    output logic                     ps_mul_otreg,
    output logic [3:0]               ps_mul_dtsts,
    output logic [1:0]               ps_mul_cls,
    output logic                     ps_shf_en,
    output logic [1:0]               ps_shf_cls,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_wadd,
    output logic [SIGNAL_WIDTH-1:0]  ps_xb_w_cuEn,
    output logic                     ps_xb_w_bcEn,
    input  logic                     alu_ps_az,
    input  logic                     alu_ps_an,
    input  logic                     alu_ps_ac,
    input  logic                     alu_ps_av,
    input  logic                     mul_ps_mv,
    input  logic                     mul_ps_mn,
    input  logic                     shf_ps_sv,
    input  logic                     shf_ps_sz,
    input  logic                     stky_clr,
    output logic [7:0]               astat,
    output logic [2:0]               stky
);

    localparam logic [1:0] UNIT_ALU = 2'b00;
    localparam logic [1:0] UNIT_MUL = 2'b01;
    localparam logic [1:0] UNIT_SHF = 2'b10;
    localparam logic [1:0] UNIT_NOP = 2'b11;

    // Instruction fields
    logic [1:0]               f_unit;
    logic [7:0]               f_op;
    logic [ADDRESS_WIDTH-1:0] f_rn, f_rx, f_ry;
    logic                     unused_rsvd;

    assign f_unit      = instr[23:22];
    assign f_op        = instr[21:14];
    assign f_rn        = instr[13:10];
    assign f_rx        = instr[9:6];
    assign f_ry        = instr[5:2];
    assign unused_rsvd = ^instr[1:0];

    // WB stage state
    logic                     wb_valid_q, wb_valid_d;
    logic [SIGNAL_WIDTH-1:0]  wb_sel_q, wb_sel_d;
    logic [ADDRESS_WIDTH-1:0] wb_rn_q, wb_rn_d;
    logic [7:0]               astat_q, astat_d;
    logic [2:0]               stky_q, stky_d;

    logic wb_active;
    logic hazard;
    logic accept;

    // A WB slot is squashed in the reset cycle so a late reset never writes.
    assign wb_active   = wb_valid_q & ~reset;
    assign hazard      = wb_active & instr_valid &
                         ((wb_rn_q == f_rx) | (wb_rn_q == f_ry));
    assign instr_ready = ~hazard;
    assign accept      = instr_valid & instr_ready & ~reset;

    // Write-back source select: one bit per unit, only during an active WB.
    generate
        for (genvar gi = 0; gi < SIGNAL_WIDTH; gi++) begin : g_unit_sel
            assign wb_sel_d[gi]     = (f_unit == 2'(gi));
            assign ps_xb_w_cuEn[gi] = wb_active & wb_sel_q[gi];
        end
    endgenerate

    assign wb_valid_d = accept & (f_unit != UNIT_NOP);
    assign wb_rn_d    = f_rn;

    // Bus-connect only gets the write port when compute WB leaves it idle.
    assign bc_wr_ack    = bc_wr_req & ~wb_active & ~reset;
    assign ps_xb_w_bcEn = bc_wr_ack;
    assign ps_xb_wadd   = wb_active ? wb_rn_q :
                          (bc_wr_ack ? bc_wr_addr : '0);

    // EX decode: all controls are zero unless an instruction is accepted.
    always_comb begin
        ps_alu_en    = 1'b0;
        ps_alu_log   = 1'b0;
        ps_alu_hc    = 2'b00;
        ps_alu_sc    = 3'b000;
        ps_alu_sat   = 1'b0;
        ps_mul_en    = 1'b0;
        ps_mul_otreg = 1'b0;
        ps_mul_dtsts = 4'h0;
        ps_mul_cls   = 2'b00;
        ps_shf_en    = 1'b0;
        ps_shf_cls   = 2'b00;
        ps_xb_raddx  = '0;
        ps_xb_raddy  = '0;
        if (accept) begin
            ps_xb_raddx = f_rx;
            ps_xb_raddy = f_ry;
            case (f_unit)
                UNIT_ALU: begin
                    ps_alu_en  = 1'b1;
                    ps_alu_log = f_op[7];
                    ps_alu_hc  = f_op[6:5];
                    ps_alu_sc  = f_op[4:2];
                    ps_alu_sat = f_op[1];
                end
                UNIT_MUL: begin
                    ps_mul_en    = 1'b1;
                    ps_mul_otreg = f_op[7];
                    ps_mul_dtsts = f_op[6:3];
                    ps_mul_cls   = f_op[2:1];
                end
                UNIT_SHF: begin
                    ps_shf_en  = 1'b1;
                    ps_shf_cls = f_op[1:0];
                end
                default: ;
            endcase
        end
    end

    // Status capture: only the writing unit's ASTAT bits move; a sticky set in
    // the same cycle as a clear survives the clear.
    always_comb begin
        astat_d = astat_q;
        stky_d  = stky_clr ? 3'b000 : stky_q;
        if (wb_active) begin
            if (wb_sel_q[0]) begin
                astat_d[3:0] = {alu_ps_av, alu_ps_ac, alu_ps_an, alu_ps_az};
                stky_d[0]    = stky_d[0] | alu_ps_av;
            end
            if (wb_sel_q[1]) begin
                astat_d[5:4] = {mul_ps_mn, mul_ps_mv};
                stky_d[1]    = stky_d[1] | mul_ps_mv;
            end
            if (wb_sel_q[2]) begin
                astat_d[7:6] = {shf_ps_sz, shf_ps_sv};
                stky_d[2]    = stky_d[2] | shf_ps_sv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_sel_q   <= '0;
            wb_rn_q    <= '0;
            astat_q    <= 8'h00;
            stky_q     <= 3'b000;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_sel_q   <= wb_sel_d;
            wb_rn_q    <= wb_rn_d;
            astat_q    <= astat_d;
            stky_q     <= stky_d;
        end
    end

    assign astat = astat_q;
    assign stky  = stky_q;

endmodule

// File: tb/tb_cu_dispatch.sv
// Testbench for cu_dispatch. Inputs change on the falling edge, outputs are
// sampled 1 ns later; expected write-backs are queued at issue and popped in
// the following cycle.
`timescale 1ns/1ps
module tb_cu_dispatch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, instr_valid, instr_ready;
    logic [23:0] instr;
    logic        bc_wr_req, bc_wr_ack;
    logic [3:0]  bc_wr_addr;
    logic        ps_alu_en, ps_alu_log, ps_alu_sat;
    logic [1:0]  ps_alu_hc;
    logic [2:0]  ps_alu_sc;
    logic        ps_mul_en, ps_mul_otreg;
    logic [3:0]  ps_mul_dtsts;
    logic [1:0]  ps_mul_cls;
    logic        ps_shf_en;
    logic [1:0]  ps_shf_cls;
    logic [3:0]  ps_xb_raddx, ps_xb_raddy, ps_xb_wadd;
    logic [2:0]  ps_xb_w_cuEn;
    logic        ps_xb_w_bcEn;
    logic        alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av;
    logic        mul_ps_mv, mul_ps_mn, shf_ps_sv, shf_ps_sz;
    logic        stky_clr;
    logic [7:0]  astat;
    logic [2:0]  stky;

    cu_dispatch #(.ADDRESS_WIDTH(4), .SIGNAL_WIDTH(3)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .bc_wr_req(bc_wr_req), .bc_wr_addr(bc_wr_addr), .bc_wr_ack(bc_wr_ack),
        .ps_alu_en(ps_alu_en), .ps_alu_log(ps_alu_log), .ps_alu_hc(ps_alu_hc),
        .ps_alu_sc(ps_alu_sc), .ps_alu_sat(ps_alu_sat),
        .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg),
        .ps_mul_dtsts(ps_mul_dtsts), .ps_mul_cls(ps_mul_cls),
        .ps_shf_en(ps_shf_en), .ps_shf_cls(ps_shf_cls),
        .ps_xb_raddx(ps_xb_raddx), .ps_xb_raddy(ps_xb_raddy),
        .ps_xb_wadd(ps_xb_wadd), .ps_xb_w_cuEn(ps_xb_w_cuEn),
        .ps_xb_w_bcEn(ps_xb_w_bcEn),
        .alu_ps_az(alu_ps_az), .alu_ps_an(alu_ps_an), .alu_ps_ac(alu_ps_ac),
        .alu_ps_av(alu_ps_av), .mul_ps_mv(mul_ps_mv), .mul_ps_mn(mul_ps_mn),
        .shf_ps_sv(shf_ps_sv), .shf_ps_sz(shf_ps_sz),
        .stky_clr(stky_clr), .astat(astat), .stky(stky)
    );

    typedef struct {
        logic [3:0] wadd;
        logic [2:0] cuen;
    } wb_t;

    wb_t        wb_q[$];
    wb_t        wb_e;
    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] exp_astat    = 8'h00;
    logic [2:0] exp_stky     = 3'b000;

    function automatic logic [23:0] mk(input logic [1:0] u, input logic [7:0] op,
                                       input logic [3:0] rn, input logic [3:0] rx,
                                       input logic [3:0] ry);
        return {u, op, rn, rx, ry, 2'b00};
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic clear_flags;
        {alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av} = 4'h0;
        {mul_ps_mv, mul_ps_mn, shf_ps_sv, shf_ps_sz} = 4'h0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick; #1;
        tests_run++;
        if (instr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 1", instr_ready);
        end
        tests_run++;
        if ({ps_alu_en, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat, ps_mul_en,
             ps_mul_otreg, ps_mul_dtsts, ps_mul_cls, ps_shf_en, ps_shf_cls,
             ps_xb_raddx, ps_xb_raddy, ps_xb_wadd, ps_xb_w_cuEn, ps_xb_w_bcEn,
             bc_wr_ack} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: some control output nonzero, want all 0");
        end
        tests_run++;
        if ({astat, stky} !== 11'h0) begin
            tests_failed++;
            $display("FAIL reset_status: astat=%h stky=%b want 00/000", astat, stky);
        end
        reset = 1'b0;
        $display("[TB] reset released");
    endtask

    task automatic test_alu;
        tick;
        instr_valid = 1'b1;
        instr = mk(2'b00, 8'hA2, 4'd3, 4'd1, 4'd2);
        #1;
        $display("[TB] issue ALU instr=%h", instr);
        tests_run++;
        if ({instr_ready, ps_alu_en, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat} !== 9'b1_1_1_01_000_1) begin
            tests_failed++;
            $display("FAIL alu_decode: got ready/en/log/hc/sc/sat=%b want 111010001",
                     {instr_ready, ps_alu_en, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat});
        end
        tests_run++;
        if ({ps_xb_raddx, ps_xb_raddy, ps_mul_en, ps_shf_en, ps_xb_w_cuEn} !== {4'd1, 4'd2, 1'b0, 1'b0, 3'b000}) begin
            tests_failed++;
            $display("FAIL alu_raddr: got raddx=%0d raddy=%0d mul=%b shf=%b cuEn=%b want 1 2 0 0 000",
                     ps_xb_raddx, ps_xb_raddy, ps_mul_en, ps_shf_en, ps_xb_w_cuEn);
        end
        wb_q.push_back('{wadd: 4'd3, cuen: 3'b001});

        tick;
        instr_valid = 1'b0;
        instr = '0;
        {alu_ps_av, alu_ps_ac, alu_ps_an, alu_ps_az} = 4'b1101;
        exp_astat[3:0] = 4'b1101;
        exp_stky[0] = 1'b1;
        #1;
        tests_run++;
        if (wb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL alu_wb: scoreboard empty");
        end else begin
            wb_e = wb_q.pop_front();
            if ({ps_xb_wadd, ps_xb_w_cuEn, ps_xb_w_bcEn} !== {wb_e.wadd, wb_e.cuen, 1'b0}) begin
                tests_failed++;
                $display("FAIL alu_wb: got wadd=%0d cuEn=%b bcEn=%b want %0d %b 0",
                         ps_xb_wadd, ps_xb_w_cuEn, ps_xb_w_bcEn, wb_e.wadd, wb_e.cuen);
            end
        end

        tick;
        clear_flags();
        #1;
        tests_run++;
        if ({astat, stky} !== {exp_astat, exp_stky}) begin
            tests_failed++;
            $display("FAIL alu_flags: got astat=%h stky=%b want %h %b", astat, stky, exp_astat, exp_stky);
        end
    endtask

    task automatic test_interlock;
        tick;
        instr_valid = 1'b1;
        instr = mk(2'b01, 8'hB6, 4'd5, 4'd6, 4'd7);
        #1;
        $display("[TB] issue MUL instr=%h", instr);
        tests_run++;
        if ({instr_ready, ps_mul_en, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls, ps_alu_en} !== {1'b1, 1'b1, 1'b1, 4'h6, 2'b11, 1'b0}) begin
            tests_failed++;
            $display("FAIL mul_decode: got ready/en/otreg/dtsts/cls/alu=%b want 1110110110",
                     {instr_ready, ps_mul_en, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls, ps_alu_en});
        end
        wb_q.push_back('{wadd: 4'd5, cuen: 3'b010});

        tick;
        instr = mk(2'b00, 8'h00, 4'd8, 4'd5, 4'd9);
        mul_ps_mv = 1'b1;
        mul_ps_mn = 1'b0;
        exp_astat[5:4] = 2'b01;
        exp_stky[1] = 1'b1;
        #1;
        $display("[TB] present dependent ALU instr=%h", instr);
        tests_run++;
        if ({instr_ready, ps_alu_en} !== 2'b00) begin
            tests_failed++;
            $display("FAIL raw_stall: got ready=%b alu_en=%b want 0 0", instr_ready, ps_alu_en);
        end
        tests_run++;
        if (wb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL mul_wb: scoreboard empty");
        end else begin
            wb_e = wb_q.pop_front();
            if ({ps_xb_wadd, ps_xb_w_cuEn} !== {wb_e.wadd, wb_e.cuen}) begin
                tests_failed++;
                $display("FAIL mul_wb: got wadd=%0d cuEn=%b want %0d %b",
                         ps_xb_wadd, ps_xb_w_cuEn, wb_e.wadd, wb_e.cuen);
            end
        end

        tick;
        clear_flags();
        #1;
        tests_run++;
        if ({instr_ready, ps_alu_en, ps_xb_raddx, ps_xb_w_cuEn} !== {1'b1, 1'b1, 4'd5, 3'b000}) begin
            tests_failed++;
            $display("FAIL raw_issue: got ready=%b alu_en=%b raddx=%0d cuEn=%b want 1 1 5 000",
                     instr_ready, ps_alu_en, ps_xb_raddx, ps_xb_w_cuEn);
        end
        tests_run++;
        if (astat !== exp_astat) begin
            tests_failed++;
            $display("FAIL mul_flags: got astat=%h want %h", astat, exp_astat);
        end
        wb_q.push_back('{wadd: 4'd8, cuen: 3'b001});

        tick;
        instr_valid = 1'b0;
        exp_astat[3:0] = 4'h0;
        #1;
        tests_run++;
        if (wb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL stalled_alu_wb: scoreboard empty");
        end else begin
            wb_e = wb_q.pop_front();
            if ({ps_xb_wadd, ps_xb_w_cuEn} !== {wb_e.wadd, wb_e.cuen}) begin
                tests_failed++;
                $display("FAIL stalled_alu_wb: got wadd=%0d cuEn=%b want %0d %b",
                         ps_xb_wadd, ps_xb_w_cuEn, wb_e.wadd, wb_e.cuen);
            end
        end

        tick;
        #1;
        tests_run++;
        if ({astat, stky} !== {exp_astat, exp_stky}) begin
            tests_failed++;
            $display("FAIL interlock_status: got astat=%h stky=%b want %h %b", astat, stky, exp_astat, exp_stky);
        end
    endtask

    task automatic test_bus_connect;
        tick;
        instr_valid = 1'b1;
        instr = mk(2'b10, 8'h03, 4'd10, 4'd11, 4'd12);
        #1;
        $display("[TB] issue SHF instr=%h", instr);
        tests_run++;
        if ({ps_shf_en, ps_shf_cls, ps_alu_en, ps_mul_en} !== 5'b1_11_0_0) begin
            tests_failed++;
            $display("FAIL shf_decode: got en/cls/alu/mul=%b want 11100",
                     {ps_shf_en, ps_shf_cls, ps_alu_en, ps_mul_en});
        end
        wb_q.push_back('{wadd: 4'd10, cuen: 3'b100});

        tick;
        instr_valid = 1'b0;
        bc_wr_req = 1'b1;
        bc_wr_addr = 4'd7;
        shf_ps_sv = 1'b0;
        shf_ps_sz = 1'b1;
        exp_astat[7:6] = 2'b10;
        #1;
        $display("[TB] bus-connect request addr=%0d", bc_wr_addr);
        tests_run++;
        if (wb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL bc_blocked: scoreboard empty");
        end else begin
            wb_e = wb_q.pop_front();
            if ({bc_wr_ack, ps_xb_w_bcEn, ps_xb_wadd, ps_xb_w_cuEn} !== {1'b0, 1'b0, wb_e.wadd, wb_e.cuen}) begin
                tests_failed++;
                $display("FAIL bc_blocked: got ack=%b bcEn=%b wadd=%0d cuEn=%b want 0 0 %0d %b",
                         bc_wr_ack, ps_xb_w_bcEn, ps_xb_wadd, ps_xb_w_cuEn, wb_e.wadd, wb_e.cuen);
            end
        end

        tick;
        clear_flags();
        #1;
        tests_run++;
        if ({bc_wr_ack, ps_xb_w_bcEn, ps_xb_wadd, ps_xb_w_cuEn} !== {1'b1, 1'b1, 4'd7, 3'b000}) begin
            tests_failed++;
            $display("FAIL bc_granted: got ack=%b bcEn=%b wadd=%0d cuEn=%b want 1 1 7 000",
                     bc_wr_ack, ps_xb_w_bcEn, ps_xb_wadd, ps_xb_w_cuEn);
        end

        tick;
        bc_wr_req = 1'b0;
        bc_wr_addr = 4'd0;
        #1;
        tests_run++;
        if ({bc_wr_ack, ps_xb_w_bcEn, astat} !== {1'b0, 1'b0, exp_astat}) begin
            tests_failed++;
            $display("FAIL bc_idle: got ack=%b bcEn=%b astat=%h want 0 0 %h",
                     bc_wr_ack, ps_xb_w_bcEn, astat, exp_astat);
        end
    endtask

    task automatic test_sticky;
        tick;
        instr_valid = 1'b1;
        instr = mk(2'b10, 8'h01, 4'd13, 4'd14, 4'd15);
        #1;
        $display("[TB] issue SHF instr=%h", instr);
        wb_q.push_back('{wadd: 4'd13, cuen: 3'b100});

        tick;
        instr_valid = 1'b0;
        shf_ps_sv = 1'b1;
        stky_clr = 1'b1;
        exp_astat[7:6] = 2'b01;
        exp_stky = 3'b100;
        #1;
        tests_run++;
        if (wb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sticky_wb: scoreboard empty");
        end else begin
            wb_e = wb_q.pop_front();
            if ({ps_xb_wadd, ps_xb_w_cuEn} !== {wb_e.wadd, wb_e.cuen}) begin
                tests_failed++;
                $display("FAIL sticky_wb: got wadd=%0d cuEn=%b want %0d %b",
                         ps_xb_wadd, ps_xb_w_cuEn, wb_e.wadd, wb_e.cuen);
            end
        end

        tick;
        clear_flags();
        stky_clr = 1'b0;
        #1;
        tests_run++;
        if ({astat, stky} !== {exp_astat, exp_stky}) begin
            tests_failed++;
            $display("FAIL set_beats_clr: got astat=%h stky=%b want %h %b", astat, stky, exp_astat, exp_stky);
        end

        tick;
        stky_clr = 1'b1;
        tick;
        stky_clr = 1'b0;
        exp_stky = 3'b000;
        #1;
        tests_run++;
        if (stky !== exp_stky) begin
            tests_failed++;
            $display("FAIL sticky_clear: got stky=%b want %b", stky, exp_stky);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] units [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
        logic [2:0] onehot;
        for (int i = 0; i < 4; i++) begin
            tick;
            instr_valid = 1'b1;
            instr = mk(units[i], 8'h00, 4'(i + 1), 4'(i + 8), 4'(i + 12));
            onehot = 3'b001 << units[i];
            #1;
            $display("[TB] back-to-back issue %0d instr=%h", i, instr);
            tests_run++;
            if ({instr_ready, ps_shf_en, ps_mul_en, ps_alu_en} !== {1'b1, onehot}) begin
                tests_failed++;
                $display("FAIL b2b_issue%0d: got ready=%b en=%b want 1 %b",
                         i, instr_ready, {ps_shf_en, ps_mul_en, ps_alu_en}, onehot);
            end
            if (i > 0) begin
                tests_run++;
                if (wb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_wb%0d: scoreboard empty", i);
                end else begin
                    wb_e = wb_q.pop_front();
                    if ({ps_xb_wadd, ps_xb_w_cuEn} !== {wb_e.wadd, wb_e.cuen}) begin
                        tests_failed++;
                        $display("FAIL b2b_wb%0d: got wadd=%0d cuEn=%b want %0d %b",
                                 i, ps_xb_wadd, ps_xb_w_cuEn, wb_e.wadd, wb_e.cuen);
                    end
                end
            end
            wb_q.push_back('{wadd: 4'(i + 1), cuen: onehot});
        end
        tick;
        instr_valid = 1'b0;
        exp_astat = 8'h00;
        #1;
        tests_run++;
        if (wb_q.size() != 1) begin
            tests_failed++;
            $display("FAIL b2b_drain: scoreboard holds %0d entries want 1", wb_q.size());
        end else begin
            wb_e = wb_q.pop_front();
            if ({ps_xb_wadd, ps_xb_w_cuEn} !== {wb_e.wadd, wb_e.cuen}) begin
                tests_failed++;
                $display("FAIL b2b_drain: got wadd=%0d cuEn=%b want %0d %b",
                         ps_xb_wadd, ps_xb_w_cuEn, wb_e.wadd, wb_e.cuen);
            end
        end
        tick;
        #1;
        tests_run++;
        if (astat !== exp_astat) begin
            tests_failed++;
            $display("FAIL b2b_astat: got astat=%h want %h", astat, exp_astat);
        end
    endtask

    task automatic test_reset_mid;
        tick;
        instr_valid = 1'b1;
        instr = mk(2'b00, 8'hA2, 4'd4, 4'd5, 4'd6);
        {alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av} = 4'hF;
        #1;
        $display("[TB] issue ALU then reset instr=%h", instr);
        tests_run++;
        if (ps_alu_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_issue: got alu_en=%b want 1", ps_alu_en);
        end

        tick;
        instr_valid = 1'b0;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({ps_xb_w_cuEn, ps_xb_wadd} !== 7'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_wb: got cuEn=%b wadd=%0d want 000 0", ps_xb_w_cuEn, ps_xb_wadd);
        end

        tick;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({astat, stky, ps_xb_w_cuEn} !== 14'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_status: got astat=%h stky=%b cuEn=%b want 00 000 000",
                     astat, stky, ps_xb_w_cuEn);
        end
        clear_flags();
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        bc_wr_req = 1'b0;
        bc_wr_addr = '0;
        stky_clr = 1'b0;
        clear_flags();

        test_reset();
        test_alu();
        test_interlock();
        test_bus_connect();
        test_sticky();
        test_back_to_back();
        test_reset_mid();

        tick;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
